// File: rtl/moore_seq_detector_param.sv
// Parametrised Moore sequence detector.
// Serial bits in, detect out while the whole pattern has been matched.
// The pattern can be reloaded at run time, matches may overlap or not, and a
// saturating counter records how many matches were seen.
module moore_seq_detector_param #(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1010,
  parameter int                 CNT_W   = 8,
  localparam int                SW      = $clog2(PAT_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inbit,
  input  logic               in_valid,
  input  logic               overlap,
  input  logic               pattern_load,
  input  logic [PAT_LEN-1:0] pattern_in,
  input  logic               clear_count,
  output logic               detect,
  output logic [SW-1:0]      state_dbg,
  output logic [CNT_W-1:0]   match_count,
  output logic               count_sat
);

  // Bit-select width for pattern indices.
  localparam int IW = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;

  // State k means the first k pattern bits have been matched.
  typedef logic [SW-1:0] state_t;
  localparam state_t S0    = '0;
  localparam state_t S_PAT = SW'(PAT_LEN);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t               state_q, state_d;
  logic [PAT_LEN-1:0]   pat_q, pat_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 sat_q, sat_d;

  state_t               nxt_tab [PAT_LEN+1];
  state_t               src_st;
  state_t               nxt_st;
  logic                 inc;

  // Successor of every state for the current inbit: the longest prefix of the
  // pattern that is a suffix of (matched prefix, inbit). Ascending j, so the
  // longest fitting candidate is the one left standing.
  always_comb begin
    logic ok;
    logic sb;
    int   idx;
    ok  = 1'b0;
    sb  = 1'b0;
    idx = 0;
    for (int k = 0; k <= PAT_LEN; k++) begin
      nxt_tab[k] = S0;
      for (int j = 1; j <= PAT_LEN; j++) begin
        if (j <= k + 1) begin
          ok = 1'b1;
          for (int t = 0; t < j; t++) begin
            idx = k + 1 - j + t;
            if (idx == k) sb = inbit;
            else          sb = pat_q[IW'(PAT_LEN - 1 - idx)];
            if (sb != pat_q[IW'(PAT_LEN - 1 - t)]) ok = 1'b0;
          end
          if (ok) nxt_tab[k] = SW'(j);
        end
      end
    end
  end

  // Without overlap a completed match restarts from scratch.
  assign src_st = (state_q == S_PAT && !overlap) ? S0 : state_q;
  assign nxt_st = nxt_tab[src_st];

  // Next state, pattern register and match counter; load beats a valid bit,
  // clear beats an increment.
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    inc     = 1'b0;
    if (pattern_load) begin
      pat_d   = pattern_in;
      state_d = S0;
    end else if (in_valid) begin
      state_d = nxt_st;
      inc     = (nxt_st == S_PAT);
    end
    if (clear_count) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end else if (inc && cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + 1'b1;
      sat_d = sat_q | (cnt_d == CNT_MAX);
    end
  end

  // State, pattern and counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S0;
      pat_q   <= PATTERN;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
    end
  end

  assign detect      = (state_q == S_PAT);
  assign state_dbg   = state_q;
  assign match_count = cnt_q;
  assign count_sat   = sat_q;

endmodule

// File: tb/tb_moore_seq_detector_param.sv
// Directed bench for moore_seq_detector_param: a default instance (CNT_W=8)
// and a narrow-counter instance (CNT_W=2) share the same stimulus.
module tb_moore_seq_detector_param;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       inbit = 1'b0;
  logic       in_valid = 1'b0;
  logic       overlap = 1'b1;
  logic       pattern_load = 1'b0;
  logic [3:0] pattern_in = 4'b0000;
  logic       clear_count = 1'b0;

  logic       detect, detect2;
  logic [2:0] state_dbg, state2;
  logic [7:0] match_count;
  logic [1:0] cnt2;
  logic       count_sat, sat2;

  int nvec = 0;
  int nerr = 0;

  moore_seq_detector_param #(.PAT_LEN(4), .PATTERN(4'b1010), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .inbit(inbit), .in_valid(in_valid),
    .overlap(overlap), .pattern_load(pattern_load), .pattern_in(pattern_in),
    .clear_count(clear_count), .detect(detect), .state_dbg(state_dbg),
    .match_count(match_count), .count_sat(count_sat)
  );

  moore_seq_detector_param #(.PAT_LEN(4), .PATTERN(4'b1010), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .inbit(inbit), .in_valid(in_valid),
    .overlap(overlap), .pattern_load(pattern_load), .pattern_in(pattern_in),
    .clear_count(clear_count), .detect(detect2), .state_dbg(state2),
    .match_count(cnt2), .count_sat(sat2)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bit_in(input logic b);
    inbit    = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Load a pattern (forces S0) and clear both counters on the same edge.
  task automatic restart(input logic [3:0] p);
    pattern_load = 1'b1;
    pattern_in   = p;
    clear_count  = 1'b1;
    tick();
    pattern_load = 1'b0;
    clear_count  = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] bits;
    logic [2:0] exp_st [4];
    tick(); tick();
    nvec++;
    if (detect !== 1'b0 || state_dbg !== 3'd0 || match_count !== 8'd0 || count_sat !== 1'b0) begin
      nerr++;
      $display("FAIL reset_init: det=%b st=%0d cnt=%0d sat=%b, expected 0/0/0/0", detect, state_dbg, match_count, count_sat);
    end
    reset = 1'b0;
    tick();
    nvec++;
    if (detect !== 1'b0 || state_dbg !== 3'd0 || match_count !== 8'd0) begin
      nerr++;
      $display("FAIL reset_release: det=%b st=%0d cnt=%0d, expected 0/0/0", detect, state_dbg, match_count);
    end
    // Swap in 1111, reach S4 with one match, then reset mid-stream.
    overlap = 1'b1;
    restart(4'b1111);
    for (int i = 0; i < 4; i++) bit_in(1'b1);
    nvec++;
    if (detect !== 1'b1 || match_count !== 8'd1) begin
      nerr++;
      $display("FAIL reset_premise: det=%b cnt=%0d, expected 1/1", detect, match_count);
    end
    reset = 1'b1;
    #15;
    nvec++;
    if (detect !== 1'b0 || state_dbg !== 3'd0 || match_count !== 8'd0 || count_sat !== 1'b0) begin
      nerr++;
      $display("FAIL reset_mid: det=%b st=%0d cnt=%0d sat=%b, expected 0/0/0/0", detect, state_dbg, match_count, count_sat);
    end
    reset = 1'b0;
    tick();
    // Pattern must be back to 1010.
    bits = 4'b1010;
    exp_st = '{3'd1, 3'd2, 3'd3, 3'd4};
    for (int i = 0; i < 4; i++) begin
      bit_in(bits[3-i]);
      nvec++;
      if (state_dbg !== exp_st[i] || detect !== (exp_st[i] == 3'd4)) begin
        nerr++;
        $display("FAIL reset_pattern bit %0d: st=%0d det=%b, expected st=%0d", i + 1, state_dbg, detect, exp_st[i]);
      end
    end
  endtask

  task automatic test_overlap();
    logic [5:0] bits;
    logic [2:0] exp_st [6];
    overlap = 1'b1;
    restart(4'b1010);
    bits = 6'b101010;
    exp_st = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd3, 3'd4};
    for (int i = 0; i < 6; i++) begin
      bit_in(bits[5-i]);
      nvec++;
      if (state_dbg !== exp_st[i] || detect !== (exp_st[i] == 3'd4)) begin
        nerr++;
        $display("FAIL overlap bit %0d: st=%0d det=%b, expected st=%0d", i + 1, state_dbg, detect, exp_st[i]);
      end
    end
    nvec++;
    if (match_count !== 8'd2) begin
      nerr++;
      $display("FAIL overlap_count: cnt=%0d, expected 2", match_count);
    end
  endtask

  task automatic test_non_overlap();
    logic [7:0] bits;
    logic [2:0] exp_st [8];
    overlap = 1'b0;
    restart(4'b1010);
    bits = 8'b10101010;
    exp_st = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd1, 3'd2, 3'd3, 3'd4};
    for (int i = 0; i < 8; i++) begin
      bit_in(bits[7-i]);
      nvec++;
      if (state_dbg !== exp_st[i] || detect !== (exp_st[i] == 3'd4)) begin
        nerr++;
        $display("FAIL non_overlap bit %0d: st=%0d det=%b, expected st=%0d", i + 1, state_dbg, detect, exp_st[i]);
      end
    end
    nvec++;
    if (match_count !== 8'd2) begin
      nerr++;
      $display("FAIL non_overlap_count: cnt=%0d, expected 2", match_count);
    end
  endtask

  task automatic test_stall();
    overlap = 1'b1;
    restart(4'b1010);
    bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
    for (int i = 0; i < 3; i++) begin
      inbit = i[0];
      tick();
      nvec++;
      if (state_dbg !== 3'd3 || detect !== 1'b0) begin
        nerr++;
        $display("FAIL stall_hold %0d: st=%0d det=%b, expected 3/0", i, state_dbg, detect);
      end
    end
    bit_in(1'b0);
    nvec++;
    if (state_dbg !== 3'd4 || detect !== 1'b1 || match_count !== 8'd1) begin
      nerr++;
      $display("FAIL stall_final: st=%0d det=%b cnt=%0d, expected 4/1/1", state_dbg, detect, match_count);
    end
    for (int i = 0; i < 2; i++) begin
      inbit = 1'b1;
      tick();
      nvec++;
      if (state_dbg !== 3'd4 || detect !== 1'b1 || match_count !== 8'd1) begin
        nerr++;
        $display("FAIL stall_s4 %0d: st=%0d det=%b cnt=%0d, expected 4/1/1", i, state_dbg, detect, match_count);
      end
    end
  endtask

  task automatic test_pattern_load();
    logic [2:0] exp_st [5];
    overlap = 1'b1;
    restart(4'b1111);
    exp_st = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    for (int i = 0; i < 5; i++) begin
      bit_in(1'b1);
      nvec++;
      if (state_dbg !== exp_st[i] || detect !== (exp_st[i] == 3'd4)) begin
        nerr++;
        $display("FAIL load_ones bit %0d: st=%0d det=%b, expected st=%0d", i + 1, state_dbg, detect, exp_st[i]);
      end
    end
    nvec++;
    if (match_count !== 8'd2) begin
      nerr++;
      $display("FAIL load_count: cnt=%0d, expected 2", match_count);
    end
    // Load mid-match with a valid bit present: load wins, state to S0.
    pattern_load = 1'b1; pattern_in = 4'b1111; tick(); pattern_load = 1'b0;
    bit_in(1'b1); bit_in(1'b1);
    pattern_load = 1'b1; inbit = 1'b1; in_valid = 1'b1;
    tick();
    pattern_load = 1'b0; in_valid = 1'b0;
    nvec++;
    if (state_dbg !== 3'd0 || detect !== 1'b0 || match_count !== 8'd2) begin
      nerr++;
      $display("FAIL load_mid: st=%0d det=%b cnt=%0d, expected 0/0/2", state_dbg, detect, match_count);
    end
    bit_in(1'b1);
    nvec++;
    if (state_dbg !== 3'd1) begin
      nerr++;
      $display("FAIL load_after: st=%0d, expected 1", state_dbg);
    end
  endtask

  task automatic test_saturate();
    overlap = 1'b1;
    restart(4'b1111);
    for (int i = 0; i < 8; i++) bit_in(1'b1);
    nvec++;
    if (cnt2 !== 2'd3 || sat2 !== 1'b1) begin
      nerr++;
      $display("FAIL sat_narrow: cnt=%0d sat=%b, expected 3/1", cnt2, sat2);
    end
    nvec++;
    if (match_count !== 8'd5 || count_sat !== 1'b0) begin
      nerr++;
      $display("FAIL sat_wide: cnt=%0d sat=%b, expected 5/0", match_count, count_sat);
    end
    // Clear coincident with a match: clear wins, state still advances.
    clear_count = 1'b1;
    bit_in(1'b1);
    clear_count = 1'b0;
    nvec++;
    if (cnt2 !== 2'd0 || sat2 !== 1'b0 || match_count !== 8'd0 || detect2 !== 1'b1 || state2 !== 3'd4) begin
      nerr++;
      $display("FAIL clear_vs_match: cnt2=%0d sat2=%b cnt=%0d det2=%b st2=%0d, expected 0/0/0/1/4", cnt2, sat2, match_count, detect2, state2);
    end
    bit_in(1'b1);
    nvec++;
    if (cnt2 !== 2'd1 || match_count !== 8'd1 || sat2 !== 1'b0) begin
      nerr++;
      $display("FAIL count_after_clear: cnt2=%0d cnt=%0d sat2=%b, expected 1/1/0", cnt2, match_count, sat2);
    end
  endtask

  initial begin
    test_reset();
    test_overlap();
    test_non_overlap();
    test_stall();
    test_pattern_load();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
